ace_ccu_snoop_req: RTL and testbench



---
 rtl/ace_ccu_snoop_req.sv | 96 +++++++++
 tb/tb_ace_ccu_snoop_req.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ace_ccu_snoop_req.sv
// Snoop-request fan-out: broadcasts one AC request to the selected ports and queues its ctrl word.
// Latency: 0 cycles to accept when all selected ports are ready; queued ctrl is visible 1 cycle after the push.
// Backpressure: stalls while the ctrl FIFO is full; each port that accepts early is masked until the request completes.
module ace_ccu_snoop_req #(
    parameter int unsigned NumOup    = 1,
    parameter int unsigned CtrlDepth = 4,
    parameter type ac_chan_t = logic,
    parameter type ctrl_t    = struct packed { logic [NumOup-1:0] sel; }
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                ac_valid_i,
    output logic                                ac_ready_o,
    input  ac_chan_t                            ac_chan_i,
    input  ctrl_t                               ctrl_i,
    output logic     [NumOup-1:0]               ac_valids_o,
    input  logic     [NumOup-1:0]               ac_readies_i,
    output ac_chan_t [NumOup-1:0]               ac_chans_o,
    output logic                                ctrl_valid_o,
    input  logic                                ctrl_ready_i,
    output ctrl_t                               ctrl_o,
    output logic     [$clog2(CtrlDepth+1)-1:0]  fill_o
);

    localparam int unsigned FillW = $clog2(CtrlDepth + 1);
    localparam int unsigned PtrW  = (CtrlDepth > 1) ? $clog2(CtrlDepth) : 1;

    logic [NumOup-1:0] done_q;
    logic [NumOup-1:0] sel;
    logic [NumOup-1:0] port_hs;
    logic [NumOup-1:0] port_ok;
    logic              space;
    logic              push;
    logic              pop;

    ctrl_t             mem_q [CtrlDepth];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [FillW-1:0]  fill_q;

    assign sel   = ctrl_i.sel;
    // A pop in the same cycle does not free a slot: no full-bypass path.
    assign space = (fill_q < FillW'(CtrlDepth));

    assign ac_valids_o = {NumOup{ac_valid_i & space}} & sel & ~done_q;
    assign port_hs     = ac_valids_o & ac_readies_i;
    assign port_ok     = ~sel | done_q | port_hs;
    assign ac_ready_o  = ac_valid_i & space & (&port_ok);

    for (genvar j = 0; j < NumOup; j++) begin : g_chan
        assign ac_chans_o[j] = ac_chan_i;
    end

    assign push         = ac_ready_o;
    assign ctrl_valid_o = (fill_q != '0);
    assign pop          = ctrl_valid_o & ctrl_ready_i;
    assign ctrl_o       = mem_q[rd_ptr_q];
    assign fill_o       = fill_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            done_q <= '0;
        end else if (push) begin
            done_q <= '0;
        end else begin
            done_q <= done_q | port_hs;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ctrl_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PtrW'(CtrlDepth - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(CtrlDepth - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   fill_q <= fill_q + 1'b1;
                2'b01:   fill_q <= fill_q - 1'b1;
                default: fill_q <= fill_q;
            endcase
        end
    end

endmodule

// File: tb/tb_ace_ccu_snoop_req.sv
// Bench for ace_ccu_snoop_req: directed scenarios plus random traffic against a queue-based reference model.
module tb_ace_ccu_snoop_req;

    typedef struct packed {
        logic [3:0] tag;
        logic [3:0] sel;
    } ctrl_t;

    logic             clk;
    logic             rst;
    logic             ac_valid;
    logic             ac_ready;
    logic [7:0]       ac_chan;
    ctrl_t            ctrl_in;
    logic [3:0]       ac_valids;
    logic [3:0]       ac_readies;
    logic [3:0][7:0]  ac_chans;
    logic             ctrl_valid;
    logic             ctrl_ready;
    ctrl_t            ctrl_out;
    logic [2:0]       fill;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: outstanding ctrl words in order, and the ports that already took the current request.
    ctrl_t      exp_q [$];
    logic [3:0] served;

    ace_ccu_snoop_req #(
        .NumOup    (4),
        .CtrlDepth (4),
        .ac_chan_t (logic [7:0]),
        .ctrl_t    (ctrl_t)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ac_valid_i   (ac_valid),
        .ac_ready_o   (ac_ready),
        .ac_chan_i    (ac_chan),
        .ctrl_i       (ctrl_in),
        .ac_valids_o  (ac_valids),
        .ac_readies_i (ac_readies),
        .ac_chans_o   (ac_chans),
        .ctrl_valid_o (ctrl_valid),
        .ctrl_ready_i (ctrl_ready),
        .ctrl_o       (ctrl_out),
        .fill_o       (fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check combinational and registered outputs, then advance the model.
    task automatic cycle(input logic v, input logic [7:0] ch, input ctrl_t c,
                         input logic [3:0] rd, input logic cr, input logic r, output logic acc);
        logic [3:0] exp_v;
        logic [3:0] hs;
        logic       sp;
        logic       exp_acc;
        ac_valid   = v;
        ac_chan    = ch;
        ctrl_in    = c;
        ac_readies = rd;
        ctrl_ready = cr;
        rst        = r;
        #1;
        sp      = (exp_q.size() < 4);
        exp_v   = (v && sp) ? (c.sel & ~served) : 4'h0;
        hs      = exp_v & rd;
        exp_acc = v && sp && ((~c.sel | served | hs) == 4'hF);
        check("ac_valids", 32'(ac_valids), 32'(exp_v));
        check("ac_ready", 32'(ac_ready), 32'(exp_acc));
        check("fill", 32'(fill), 32'(exp_q.size()));
        check("ctrl_valid", 32'(ctrl_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) check("ctrl_o", 32'(ctrl_out), 32'(exp_q[0]));
        for (int j = 0; j < 4; j++) check("ac_chans", 32'(ac_chans[j]), 32'(ch));
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            served = 4'h0;
        end else begin
            if (cr && exp_q.size() != 0) void'(exp_q.pop_front());
            if (exp_acc) begin
                exp_q.push_back(c);
                served = 4'h0;
            end else begin
                served = served | hs;
            end
        end
        acc = exp_acc && !r;
        #2;
    endtask

    initial begin
        logic       acc;
        logic       have_req;
        logic [7:0] cur_ch;
        ctrl_t      cur_c;
        ctrl_t      idle_c;
        idle_c   = '0;
        served   = 4'h0;
        have_req = 1'b0;
        cur_ch   = '0;
        cur_c    = '0;

        cycle(0, 8'h00, idle_c, 4'h0, 0, 1, acc);
        cycle(0, 8'h00, idle_c, 4'h0, 0, 1, acc);
        cycle(0, 8'h00, idle_c, 4'hF, 1, 0, acc);
        check("reset_fill", 32'(fill), 32'd0);
        check("reset_ctrl_valid", 32'(ctrl_valid), 32'd0);

        // Full fan-out in one cycle.
        cycle(1, 8'hA5, '{tag: 4'h1, sel: 4'b1011}, 4'hF, 0, 0, acc);
        check("fanout_acc", 32'(acc), 32'd1);
        cycle(0, 8'h00, idle_c, 4'h0, 1, 0, acc);

        // Staggered readiness: port 1 early, port 2 three cycles later.
        cycle(1, 8'h3C, '{tag: 4'h2, sel: 4'b0110}, 4'b0010, 0, 0, acc);
        cycle(1, 8'h3C, '{tag: 4'h2, sel: 4'b0110}, 4'b0000, 0, 0, acc);
        cycle(1, 8'h3C, '{tag: 4'h2, sel: 4'b0110}, 4'b1011, 0, 0, acc);
        check("stagger_wait", 32'(acc), 32'd0);
        cycle(1, 8'h3C, '{tag: 4'h2, sel: 4'b0110}, 4'b0100, 0, 0, acc);
        check("stagger_acc", 32'(acc), 32'd1);

        // Fill to capacity, then a fifth request stalls until one pop.
        for (int i = 0; i < 3; i++) cycle(1, 8'(i), '{tag: 4'(3 + i), sel: 4'b0001}, 4'hF, 0, 0, acc);
        check("full_fill", 32'(fill), 32'd4);
        cycle(1, 8'h55, '{tag: 4'h7, sel: 4'b0000}, 4'hF, 1, 0, acc);
        check("full_no_acc", 32'(acc), 32'd0);
        cycle(1, 8'h55, '{tag: 4'h7, sel: 4'b0000}, 4'hF, 0, 0, acc);
        check("sel0_acc_after_pop", 32'(acc), 32'd1);

        // Drain, then reset with a partial fork pending.
        for (int i = 0; i < 5; i++) cycle(0, 8'h00, idle_c, 4'h0, 1, 0, acc);
        cycle(1, 8'h11, '{tag: 4'h8, sel: 4'b1111}, 4'b0010, 0, 0, acc);
        cycle(1, 8'h11, '{tag: 4'h8, sel: 4'b1111}, 4'b0000, 0, 1, acc);
        cycle(1, 8'h11, '{tag: 4'h8, sel: 4'b1111}, 4'b0000, 0, 0, acc);
        check("post_reset_refork", 32'(ac_valids), 32'hF);
        cycle(1, 8'h11, '{tag: 4'h8, sel: 4'b1111}, 4'hF, 0, 0, acc);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            if (!have_req && ($urandom % 4 != 0)) begin
                have_req = 1'b1;
                cur_ch   = 8'($urandom);
                cur_c    = ctrl_t'($urandom);
            end
            cycle(have_req, have_req ? cur_ch : 8'h00, have_req ? cur_c : idle_c,
                  4'($urandom), ($urandom % 3 == 0), ($urandom % 300 == 0), acc);
            if (acc) have_req = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
